vend_change_fsm: RTL and testbench

- Parametrised Moore vending controller accepting 5/10/25-rupee coin pulses, with programmable product price.
- Vends one product when accumulated credit reaches PRICE, then returns excess credit as a timed sequence of change-coin pulses.
- Supports cancel-with-refund, coin rejection on overflow or busy, and simultaneous coin inputs.
- Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_change_fsm.sv | 120 ++++++++++++
 tb/tb_vend_change_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_fsm.sv
// Moore vending controller: sums 5/10/25 coin pulses into credit, vends at PRICE and pays change.
// Define VEND_TEN_CHANGE_EN to dispense 10-rupee change coins greedily before a final 5.
module vend_change_fsm #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 95,
    parameter int CREDIT_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fiveRupees,
    input  logic                tenRupees,
    input  logic                twentyFiveRupees,
    input  logic                cancel,
    output logic                theProduct,
    output logic                changeFive,
    output logic                changeTen,
    output logic                coinReject,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          currentState
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]    PRICE_WIDE   = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0]    MAX_WIDE     = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_NARROW = CREDIT_W'(PRICE);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        ACCUM  = 3'b001,
        VEND   = 3'b010,
        CHANGE = 3'b011,
        REFUND = 3'b100
    } stateT;

    stateT               stateReg, stateNext;
    logic [CREDIT_W-1:0] creditReg, creditNext;
    logic                rejectReg, rejectNext;

    logic [SUM_W-1:0]    coinSum;
    logic [SUM_W-1:0]    creditSum;
    logic                coinsIn;
    logic                tenStep;
    logic [CREDIT_W-1:0] dispenseStep;
    logic                dispensing;

    // credit+sum carries one extra bit so the overflow test cannot wrap
    assign coinSum   = (fiveRupees       ? SUM_W'(5)  : '0)
                     + (tenRupees        ? SUM_W'(10) : '0)
                     + (twentyFiveRupees ? SUM_W'(25) : '0);
    assign creditSum = {1'b0, creditReg} + coinSum;
    assign coinsIn   = fiveRupees | tenRupees | twentyFiveRupees;

`ifdef VEND_TEN_CHANGE_EN
    assign tenStep = (creditReg >= CREDIT_W'(10));
`else
    assign tenStep = 1'b0;
`endif
    assign dispenseStep = tenStep ? CREDIT_W'(10) : CREDIT_W'(5);
    assign dispensing   = (stateReg == CHANGE) || (stateReg == REFUND);

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg  <= IDLE;
            creditReg <= '0;
            rejectReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            creditReg <= creditNext;
            rejectReg <= rejectNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        creditNext = creditReg;
        rejectNext = 1'b0;
        case (stateReg)
            IDLE, ACCUM: begin
                if (cancel) begin
                    rejectNext = coinsIn;
                    stateNext  = (creditReg != '0) ? REFUND : IDLE;
                end else if (coinsIn) begin
                    if (creditSum > MAX_WIDE) begin
                        rejectNext = 1'b1;
                    end else begin
                        creditNext = creditSum[CREDIT_W-1:0];
                        stateNext  = (creditSum >= PRICE_WIDE) ? VEND : ACCUM;
                    end
                end
            end
            VEND: begin
                rejectNext = coinsIn;
                creditNext = creditReg - PRICE_NARROW;
                stateNext  = (creditReg > PRICE_NARROW) ? CHANGE : IDLE;
            end
            CHANGE, REFUND: begin
                // change and refund pay out identically; the last coin empties credit
                rejectNext = coinsIn;
                if (creditReg <= dispenseStep) begin
                    creditNext = '0;
                    stateNext  = IDLE;
                end else begin
                    creditNext = creditReg - dispenseStep;
                end
            end
            default: begin
                stateNext  = IDLE;
                creditNext = '0;
            end
        endcase
    end

    assign theProduct   = (stateReg == VEND);
    assign changeTen    = dispensing & tenStep;
    assign changeFive   = dispensing & ~tenStep;
    assign coinReject   = rejectReg;
    assign credit       = creditReg;
    assign currentState = stateReg;

endmodule

// File: tb/tb_vend_change_fsm.sv
// Bench for vend_change_fsm: two instances (PRICE 25 and 95) driven by directed rows then random
// coins, each checked every cycle against a queue-of-expected-cycles model.
module tb_vend_change_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       prod;
        logic       five;
        logic       ten;
        logic [7:0] cr;
    } expT;

`ifdef VEND_TEN_CHANGE_EN
    localparam bit TEN_EN = 1'b1;
`else
    localparam bit TEN_EN = 1'b0;
`endif
    localparam int MAXC   = 95;
    localparam int CYCLES = 3000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset[2];
    logic       fiveIn[2], tenIn[2], quarterIn[2], cancelIn[2];
    logic       prodO[2], fiveO[2], tenO[2], rejO[2];
    logic [7:0] creditO[2];
    logic [2:0] stO[2];

    vend_change_fsm #(.PRICE(25), .MAX_CREDIT(95), .CREDIT_W(8)) dut0 (
        .clock(clock), .reset(reset[0]),
        .fiveRupees(fiveIn[0]), .tenRupees(tenIn[0]), .twentyFiveRupees(quarterIn[0]),
        .cancel(cancelIn[0]),
        .theProduct(prodO[0]), .changeFive(fiveO[0]), .changeTen(tenO[0]),
        .coinReject(rejO[0]), .credit(creditO[0]), .currentState(stO[0])
    );

    vend_change_fsm #(.PRICE(95), .MAX_CREDIT(95), .CREDIT_W(8)) dut1 (
        .clock(clock), .reset(reset[1]),
        .fiveRupees(fiveIn[1]), .tenRupees(tenIn[1]), .twentyFiveRupees(quarterIn[1]),
        .cancel(cancelIn[1]),
        .theProduct(prodO[1]), .changeFive(fiveO[1]), .changeTen(tenO[1]),
        .coinReject(rejO[1]), .credit(creditO[1]), .currentState(stO[1])
    );

    int   checks = 0;
    int   errors = 0;
    expT  cur[2];
    logic curRej[2];
    expT  pend[2][0:31];
    int   pCnt[2];
    int   pIdx[2];

    function automatic int priceOf(input int inst);
        return (inst == 0) ? 25 : 95;
    endfunction

    function automatic expT idleOf(input int c);
        expT e;
        e.st   = (c == 0) ? 3'd0 : 3'd1;
        e.prod = 1'b0;
        e.five = 1'b0;
        e.ten  = 1'b0;
        e.cr   = 8'(c);
        return e;
    endfunction

    // Row layout: [19] reset asserted, [18] pin valid, [17] pin reject, [16:14] pin state,
    // [13:6] pin credit, [3:0] {cancel, 25, 10, 5}. Pins check the outputs seen before the row drives.
    function automatic logic [19:0] mk(input bit r, input bit pv, input bit pr,
                                       input int ps, input int pc, input int inp);
        return {r, pv, pr, 3'(ps), 8'(pc), 2'b00, 4'(inp)};
    endfunction

    function automatic int dirLen(input int inst);
        return (inst == 0) ? 23 : 10;
    endfunction

    function automatic logic [19:0] dirRow(input int inst, input int i);
        logic [19:0] r;
        r = '0;
        if (inst == 0) begin
            case (i)
                0:  r = mk(0, 1, 0, 0, 0, 1);
                1:  r = mk(0, 1, 0, 1, 5, 2);
                2:  r = mk(0, 1, 0, 1, 15, 2);
                3:  r = mk(0, 1, 0, 2, 25, 0);
                4:  r = mk(0, 1, 0, 0, 0, 6);
                5:  r = mk(0, 1, 0, 2, 35, 1);
                6:  r = mk(0, 1, 1, 3, 10, 1);
                8:  r = mk(0, 1, 0, 0, 0, 0);
                9:  r = mk(0, 0, 0, 0, 0, 1);
                10: r = mk(0, 1, 0, 1, 5, 2);
                11: r = mk(0, 1, 0, 1, 15, 10);
                12: r = mk(0, 1, 1, 4, 15, 0);
                16: r = mk(0, 1, 0, 0, 0, 0);
                17: r = mk(0, 0, 0, 0, 0, 6);
                18: r = mk(0, 1, 0, 2, 35, 0);
                19: r = mk(1, 1, 0, 3, 10, 0);
                20: r = mk(1, 1, 0, 0, 0, 0);
                21: r = mk(0, 1, 0, 0, 0, 0);
                22: r = mk(0, 1, 0, 0, 0, 1);
                default: r = '0;
            endcase
        end else begin
            case (i)
                0: r = mk(0, 1, 0, 0, 0, 4);
                1: r = mk(0, 1, 0, 1, 25, 4);
                2: r = mk(0, 1, 0, 1, 50, 2);
                3: r = mk(0, 1, 0, 1, 60, 4);
                4: r = mk(0, 1, 0, 1, 85, 4);
                5: r = mk(0, 1, 1, 1, 85, 0);
                6: r = mk(0, 1, 0, 1, 85, 2);
                7: r = mk(0, 1, 0, 2, 95, 0);
                8: r = mk(0, 1, 0, 0, 0, 9);
                9: r = mk(0, 1, 1, 0, 0, 0);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic addDispense(input int inst, input int amt, input logic [2:0] st);
        int  rem;
        expT e;
        rem = amt;
        while (rem > 0) begin
            e.st   = st;
            e.prod = 1'b0;
            e.cr   = 8'(rem);
            if (TEN_EN && rem >= 10) begin
                e.ten  = 1'b1;
                e.five = 1'b0;
                rem    = rem - 10;
            end else begin
                e.ten  = 1'b0;
                e.five = 1'b1;
                rem    = rem - 5;
            end
            pend[inst][pCnt[inst]] = e;
            pCnt[inst] = pCnt[inst] + 1;
        end
    endtask

    task automatic modelStep(input int inst, input logic [3:0] inp, input logic rstA);
        int   sum, c, nc;
        expT  nxt;
        logic rej;
        sum = (inp[0] ? 5 : 0) + (inp[1] ? 10 : 0) + (inp[2] ? 25 : 0);
        c   = int'(cur[inst].cr);
        rej = 1'b0;
        nxt = cur[inst];
        if (rstA) begin
            pCnt[inst] = 0;
            pIdx[inst] = 0;
            nxt = idleOf(0);
        end else if (cur[inst].prod || cur[inst].five || cur[inst].ten) begin
            rej = (sum > 0);
            if (pIdx[inst] < pCnt[inst]) begin
                nxt = pend[inst][pIdx[inst]];
                pIdx[inst] = pIdx[inst] + 1;
            end else begin
                nxt = idleOf(0);
            end
        end else if (inp[3]) begin
            rej = (sum > 0);
            nxt = idleOf(0);
            if (c > 0) begin
                pCnt[inst] = 0;
                addDispense(inst, c, 3'd4);
                nxt = pend[inst][0];
                pIdx[inst] = 1;
            end
        end else if (sum > 0 && c + sum > MAXC) begin
            rej = 1'b1;
        end else if (sum > 0) begin
            nc = c + sum;
            if (nc >= priceOf(inst)) begin
                pend[inst][0] = '{st: 3'd2, prod: 1'b1, five: 1'b0, ten: 1'b0, cr: 8'(nc)};
                pCnt[inst] = 1;
                addDispense(inst, nc - priceOf(inst), 3'd3);
                nxt = pend[inst][0];
                pIdx[inst] = 1;
            end else begin
                nxt = idleOf(nc);
            end
        end
        cur[inst]    = nxt;
        curRej[inst] = rej;
    endtask

    task automatic checkOut(input int inst, input int cyc);
        checks = checks + 1;
        if (stO[inst] !== cur[inst].st || prodO[inst] !== cur[inst].prod ||
            fiveO[inst] !== cur[inst].five || tenO[inst] !== cur[inst].ten ||
            creditO[inst] !== cur[inst].cr || rejO[inst] !== curRej[inst]) begin
            errors = errors + 1;
            $display("FAIL outputs dut%0d cyc=%0d: got st=%0d prod=%b five=%b ten=%b credit=%0d rej=%b, expected st=%0d prod=%b five=%b ten=%b credit=%0d rej=%b",
                     inst, cyc, stO[inst], prodO[inst], fiveO[inst], tenO[inst], creditO[inst], rejO[inst],
                     cur[inst].st, cur[inst].prod, cur[inst].five, cur[inst].ten, cur[inst].cr, curRej[inst]);
        end
    endtask

    task automatic checkPin(input int inst, input int cyc, input logic [19:0] row);
        checks = checks + 1;
        if (stO[inst] !== row[16:14] || creditO[inst] !== row[13:6] || rejO[inst] !== row[17]) begin
            errors = errors + 1;
            $display("FAIL pin dut%0d row=%0d: got st=%0d credit=%0d rej=%b, expected st=%0d credit=%0d rej=%b",
                     inst, cyc, stO[inst], creditO[inst], rejO[inst], row[16:14], row[13:6], row[17]);
        end
    endtask

    initial begin
        logic [19:0] row;
        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b0;
            fiveIn[i]    = 1'b0;
            tenIn[i]     = 1'b0;
            quarterIn[i] = 1'b0;
            cancelIn[i]  = 1'b0;
            cur[i]       = idleOf(0);
            curRej[i]    = 1'b0;
            pCnt[i]      = 0;
            pIdx[i]      = 0;
        end
        repeat (2) @(posedge clock);
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clock);
            for (int inst = 0; inst < 2; inst++) begin
                checkOut(inst, cyc);
                if (cyc < dirLen(inst)) begin
                    row = dirRow(inst, cyc);
                    if (row[18]) checkPin(inst, cyc, row);
                end else begin
                    row = '0;
                    row[19] = ($urandom_range(0, 299) == 0);
                    row[0]  = ($urandom_range(0, 3) == 0);
                    row[1]  = ($urandom_range(0, 3) == 0);
                    row[2]  = ($urandom_range(0, 3) == 0);
                    row[3]  = ($urandom_range(0, 15) == 0);
                end
                reset[inst]     = ~row[19];
                fiveIn[inst]    = row[0];
                tenIn[inst]     = row[1];
                quarterIn[inst] = row[2];
                cancelIn[inst]  = row[3];
                modelStep(inst, row[3:0], row[19]);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
